// File: rtl/alpha_gamma_llr.sv
// alpha_gamma_llr: forward (alpha) half of a max-log-MAP constituent decoder.
// Computes per-step branch metrics from channel/a-priori LLRs, runs the 8-state
// normalised alpha recursion and forwards everything the backward unit needs.
module alpha_gamma_llr #(
   parameter int unsigned blklen_w = 6144
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        blklen,
   input  logic               valid_blklen,
   input  logic signed [15:0] sys,
   input  logic signed [15:0] parity,
   input  logic signed [15:0] apriori,
   input  logic               valid_in,
   output logic signed [15:0] init_branch1,
   output logic signed [15:0] init_branch2,
   output logic               valid_branch,
   output logic signed [15:0] alpha_0,
   output logic signed [15:0] alpha_1,
   output logic signed [15:0] alpha_2,
   output logic signed [15:0] alpha_3,
   output logic signed [15:0] alpha_4,
   output logic signed [15:0] alpha_5,
   output logic signed [15:0] alpha_6,
   output logic signed [15:0] alpha_7,
   output logic               valid_alpha,
   output logic signed [15:0] sys_out,
   output logic               valid_sys,
   output logic signed [15:0] apriori_out,
   output logic               valid_apriori,
   output logic [15:0]        blklen_out,
   output logic               valid_blklen_out,
   output logic               done,
   output logic [1:0]         fsm_state
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } state_e;

   state_e             state_q;
   logic [16:0]        cnt_q;
   logic [16:0]        len_q;
   logic               drain_q;

   logic               v1_q;
   logic signed [15:0] g1_q, g2_q;
   logic signed [15:0] sys1_q, apr1_q;

   logic signed [18:0] alpha_q [8];
   logic signed [18:0] alpha_d [8];
   logic signed [18:0] cand [8];
   logic signed [18:0] g1x, g2x;

   logic signed [16:0] s_sum;
   logic signed [17:0] p_sum, p_dif;
   logic signed [17:0] g1_raw, g2_raw;
   logic signed [15:0] g1_w, g2_w;

   logic               start;
   logic               accept;
   logic [15:0]        blk_clamp;

   function automatic logic signed [15:0] sat16(input logic signed [18:0] x);
      if (x > 19'sd32767) begin
         return 16'h7fff;
      end else if (x < -19'sd32768) begin
         return 16'h8000;
      end else begin
         return x[15:0];
      end
   endfunction

   function automatic logic signed [18:0] max19(input logic signed [18:0] a,
                                                 input logic signed [18:0] b);
      return (a > b) ? a : b;
   endfunction

   assign start     = (state_q == StIdle) && valid_blklen;
   assign accept    = (state_q == StRun) && valid_in;
   assign blk_clamp = (blklen > 16'(blklen_w)) ? 16'(blklen_w) : blklen;
   assign fsm_state = state_q;

   // Branch metrics: halve with floor rounding, then clip back to 16 bits.
   always_comb begin
      s_sum  = {sys[15], sys} + {apriori[15], apriori};
      p_sum  = {s_sum[16], s_sum} + {{2{parity[15]}}, parity};
      p_dif  = {s_sum[16], s_sum} - {{2{parity[15]}}, parity};
      g1_raw = p_sum >>> 1;
      g2_raw = p_dif >>> 1;
      g1_w   = sat16({g1_raw[17], g1_raw});
      g2_w   = sat16({g2_raw[17], g2_raw});
   end

   // Add-compare-select over the 8-state trellis, normalised to state 0.
   always_comb begin
      g1x     = {{3{g1_q[15]}}, g1_q};
      g2x     = {{3{g2_q[15]}}, g2_q};
      cand[0] = max19(alpha_q[0] + g1x, alpha_q[1] - g1x);
      cand[1] = max19(alpha_q[3] + g2x, alpha_q[2] - g2x);
      cand[2] = max19(alpha_q[4] + g2x, alpha_q[5] - g2x);
      cand[3] = max19(alpha_q[7] + g1x, alpha_q[6] - g1x);
      cand[4] = max19(alpha_q[1] + g1x, alpha_q[0] - g1x);
      cand[5] = max19(alpha_q[2] + g2x, alpha_q[3] - g2x);
      cand[6] = max19(alpha_q[5] + g2x, alpha_q[4] - g2x);
      cand[7] = max19(alpha_q[6] + g1x, alpha_q[7] - g1x);
      for (int t = 0; t < 8; t++) begin
         alpha_d[t] = cand[t] - cand[0];
      end
   end

   // Frame control: length latch, beat counter, drain timer and handshake pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         len_q            <= '0;
         drain_q          <= 1'b0;
         blklen_out       <= '0;
         valid_blklen_out <= 1'b0;
         done             <= 1'b0;
      end else begin
         valid_blklen_out <= 1'b0;
         done             <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (valid_blklen) begin
                  state_q          <= StRun;
                  cnt_q            <= '0;
                  len_q            <= {1'b0, blk_clamp} + 17'd4;
                  blklen_out       <= blk_clamp;
                  valid_blklen_out <= 1'b1;
               end
            end
            StRun: begin
               if (valid_in) begin
                  cnt_q <= cnt_q + 17'd1;
                  if (cnt_q + 17'd1 == len_q) begin
                     state_q <= StDrain;
                     drain_q <= 1'b0;
                  end
               end
            end
            StDrain: begin
               // Two cycles here let the last beat clear the pipeline.
               if (drain_q) begin
                  state_q <= StIdle;
                  done    <= 1'b1;
               end else begin
                  drain_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Stage 1: register branch metrics and the LLR copies for accepted beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q   <= 1'b0;
         g1_q   <= '0;
         g2_q   <= '0;
         sys1_q <= '0;
         apr1_q <= '0;
      end else begin
         v1_q <= accept;
         if (accept) begin
            g1_q   <= g1_w;
            g2_q   <= g2_w;
            sys1_q <= sys;
            apr1_q <= apriori;
         end
      end
   end

   // Alpha state: seeded at frame start, advanced once per stage-1 beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < 8; t++) begin
            alpha_q[t] <= '0;
         end
      end else if (start) begin
         alpha_q[0] <= '0;
         for (int t = 1; t < 8; t++) begin
            alpha_q[t] <= -19'sd128;
         end
      end else if (v1_q) begin
         for (int t = 0; t < 8; t++) begin
            alpha_q[t] <= alpha_d[t];
         end
      end
   end

   // Stage 2: present alpha before this step's update, paired with its metrics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_branch <= 1'b0;
         init_branch1 <= '0;
         init_branch2 <= '0;
         alpha_0      <= '0;
         alpha_1      <= '0;
         alpha_2      <= '0;
         alpha_3      <= '0;
         alpha_4      <= '0;
         alpha_5      <= '0;
         alpha_6      <= '0;
         alpha_7      <= '0;
         sys_out      <= '0;
         apriori_out  <= '0;
      end else begin
         valid_branch <= v1_q;
         if (v1_q) begin
            init_branch1 <= g1_q;
            init_branch2 <= g2_q;
            alpha_0      <= sat16(alpha_q[0]);
            alpha_1      <= sat16(alpha_q[1]);
            alpha_2      <= sat16(alpha_q[2]);
            alpha_3      <= sat16(alpha_q[3]);
            alpha_4      <= sat16(alpha_q[4]);
            alpha_5      <= sat16(alpha_q[5]);
            alpha_6      <= sat16(alpha_q[6]);
            alpha_7      <= sat16(alpha_q[7]);
            sys_out      <= sys1_q;
            apriori_out  <= apr1_q;
         end
      end
   end

   assign valid_alpha   = valid_branch;
   assign valid_sys     = valid_branch;
   assign valid_apriori = valid_branch;

endmodule

// File: tb/tb_alpha_gamma_llr.sv
// Bench for alpha_gamma_llr: random frames checked against a trellis-table model.
module tb_alpha_gamma_llr;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [15:0]        blklen = '0;
   logic               valid_blklen = 1'b0;
   logic signed [15:0] sys = '0, parity = '0, apriori = '0;
   logic               valid_in = 1'b0;
   logic signed [15:0] init_branch1, init_branch2;
   logic               valid_branch, valid_alpha, valid_sys, valid_apriori;
   logic signed [15:0] alpha_0, alpha_1, alpha_2, alpha_3;
   logic signed [15:0] alpha_4, alpha_5, alpha_6, alpha_7;
   logic signed [15:0] sys_out, apriori_out;
   logic [15:0]        blklen_out;
   logic               valid_blklen_out, done;
   logic [1:0]         fsm_state;

   always #5 clk = ~clk;

   alpha_gamma_llr dut (
      .clk(clk), .rst(rst), .blklen(blklen), .valid_blklen(valid_blklen),
      .sys(sys), .parity(parity), .apriori(apriori), .valid_in(valid_in),
      .init_branch1(init_branch1), .init_branch2(init_branch2), .valid_branch(valid_branch),
      .alpha_0(alpha_0), .alpha_1(alpha_1), .alpha_2(alpha_2), .alpha_3(alpha_3),
      .alpha_4(alpha_4), .alpha_5(alpha_5), .alpha_6(alpha_6), .alpha_7(alpha_7),
      .valid_alpha(valid_alpha), .sys_out(sys_out), .valid_sys(valid_sys),
      .apriori_out(apriori_out), .valid_apriori(valid_apriori), .blklen_out(blklen_out),
      .valid_blklen_out(valid_blklen_out), .done(done), .fsm_state(fsm_state)
   );

   // One output beat: {b1, b2, alpha0..7, sys, apriori}, 16 bits each.
   logic [191:0] cur_beat;
   logic [215:0] all_out;
   assign cur_beat = {init_branch1, init_branch2, alpha_0, alpha_1, alpha_2, alpha_3,
                      alpha_4, alpha_5, alpha_6, alpha_7, sys_out, apriori_out};
   assign all_out  = {cur_beat, valid_branch, valid_alpha, valid_sys, valid_apriori,
                      blklen_out, valid_blklen_out, done, fsm_state};

   int n_cmp = 0;
   int n_err = 0;
   int st_sys[$], st_par[$], st_apr[$];
   logic [191:0] exp_q[$], obs_q[$];
   int done_cnt = 0, vbo_cnt = 0, align_err = 0;
   int cyc = 0, first_vb_cyc = -1, vbo_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (valid_branch) begin
            obs_q.push_back(cur_beat);
            if (first_vb_cyc < 0) first_vb_cyc = cyc;
         end
         if (done) done_cnt++;
         if (valid_blklen_out) begin
            vbo_cnt++;
            vbo_cyc = cyc;
         end
         if (valid_alpha !== valid_branch || valid_sys !== valid_branch ||
             valid_apriori !== valid_branch) align_err++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int sat16(int x);
      return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
   endfunction

   function automatic int w19(int x);
      return (x <<< 13) >>> 13;
   endfunction

   function automatic int rnd(int r);
      return int'($urandom_range(2 * r, 0)) - r;
   endfunction

   // Expected beats for one frame: first blk+4 stimulus beats through the trellis.
   task automatic model_frame(input int blk);
      int a[8];
      int c[8];
      int g[3];
      int fld[12];
      int src_p[8] = '{0, 3, 4, 7, 1, 2, 5, 6};
      int src_m[8] = '{1, 2, 5, 6, 0, 3, 4, 7};
      int gsel[8]  = '{1, 2, 2, 1, 1, 2, 2, 1};
      int nb, s;
      logic [191:0] v;
      exp_q.delete();
      a[0] = 0;
      for (int t = 1; t < 8; t++) a[t] = -128;
      nb = (st_sys.size() < blk + 4) ? st_sys.size() : blk + 4;
      g[0] = 0;
      for (int k = 0; k < nb; k++) begin
         s    = st_sys[k] + st_apr[k];
         g[1] = sat16((s + st_par[k]) >>> 1);
         g[2] = sat16((s - st_par[k]) >>> 1);
         fld[0] = g[1];
         fld[1] = g[2];
         for (int t = 0; t < 8; t++) fld[2 + t] = sat16(a[t]);
         fld[10] = st_sys[k];
         fld[11] = st_apr[k];
         v = '0;
         for (int i = 0; i < 12; i++) v[191 - 16 * i -: 16] = 16'(fld[i]);
         exp_q.push_back(v);
         for (int t = 0; t < 8; t++) begin
            c[t] = w19(a[src_p[t]] + g[gsel[t]]);
            if (w19(a[src_m[t]] - g[gsel[t]]) > c[t]) c[t] = w19(a[src_m[t]] - g[gsel[t]]);
         end
         for (int t = 0; t < 8; t++) a[t] = w19(c[t] - c[0]);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_q.delete();
      done_cnt = 0;
      vbo_cnt = 0;
      first_vb_cyc = -1;
      vbo_cyc = -1;
   endtask

   task automatic gen_stim(input int n, input int r);
      st_sys.delete();
      st_par.delete();
      st_apr.delete();
      for (int i = 0; i < n; i++) begin
         st_sys.push_back(rnd(r));
         st_par.push_back(rnd(r));
         st_apr.push_back(rnd(r));
      end
   endtask

   // poke >= 0 raises a stray valid_blklen on that beat index.
   task automatic drive_frame(input int blk, input int gap_max, input int poke);
      blklen = 16'(blk);
      valid_blklen = 1'b1;
      tick();
      valid_blklen = 1'b0;
      for (int i = 0; i < st_sys.size(); i++) begin
         if (i > 0) repeat ($urandom_range(gap_max, 0)) tick();
         sys = 16'(st_sys[i]);
         parity = 16'(st_par[i]);
         apriori = 16'(st_apr[i]);
         valid_in = 1'b1;
         if (i == poke) begin
            valid_blklen = 1'b1;
            blklen = 16'd7;
         end
         tick();
         valid_in = 1'b0;
         valid_blklen = 1'b0;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (fsm_state == 2'd0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      repeat (3) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++;
         $display("FAIL reset_low: outputs %h want 0", all_out);
      end
      rst = 1'b1;
      clear_obs();
      repeat (5) tick();
      n_cmp++;
      if (all_out !== '0 || obs_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_idle: outputs %h beats %0d want 0/0", all_out, obs_q.size());
      end
   endtask

   task automatic test_gamma_recursion();
      logic [191:0] e0, e1;
      bit ok;
      e0 = {16'(10), 16'(4), 16'(0), 16'(-128), 16'(-128), 16'(-128), 16'(-128),
            16'(-128), 16'(-128), 16'(-128), 16'(10), 16'(4)};
      e1 = {16'(-2), 16'(-2), 16'(0), 16'(-134), 16'(-134), 16'(-128), 16'(-20),
            16'(-134), 16'(-134), 16'(-128), 16'(-3), 16'(0)};
      gen_stim(4, 500);
      st_sys[0] = 10; st_apr[0] = 4; st_par[0] = 6;
      st_sys[1] = -3; st_apr[1] = 0; st_par[1] = 0;
      clear_obs();
      model_frame(0);
      drive_frame(0, 0, -1);
      wait_idle(ok);
      n_cmp++;
      if (!ok || obs_q.size() != 4) begin
         n_err++;
         $display("FAIL gamma_count: idle %0d beats %0d want 1/4", ok, obs_q.size());
      end
      if (obs_q.size() >= 2) begin
         n_cmp++;
         if (obs_q[0] !== e0) begin
            n_err++;
            $display("FAIL gamma_beat0: got %h want %h", obs_q[0], e0);
         end
         n_cmp++;
         if (obs_q[1] !== e1) begin
            n_err++;
            $display("FAIL gamma_beat1: got %h want %h", obs_q[1], e1);
         end
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL gamma_model%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_frame();
      bit ok;
      // valid_in while idle must be ignored.
      clear_obs();
      sys = 16'sd100;
      valid_in = 1'b1;
      repeat (3) tick();
      valid_in = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (obs_q.size() != 0 || fsm_state !== 2'd0) begin
         n_err++;
         $display("FAIL idle_valid_in: beats %0d state %0d want 0/0", obs_q.size(), fsm_state);
      end
      gen_stim(50, 3000);
      clear_obs();
      model_frame(40);
      drive_frame(40, 2, 5);
      wait_idle(ok);
      n_cmp++;
      if (!ok || obs_q.size() != 44) begin
         n_err++;
         $display("FAIL frame_count: idle %0d beats %0d want 1/44", ok, obs_q.size());
      end
      n_cmp++;
      if (done_cnt != 1 || fsm_state !== 2'd0) begin
         n_err++;
         $display("FAIL frame_done: done %0d state %0d want 1/0", done_cnt, fsm_state);
      end
      n_cmp++;
      if (vbo_cnt != 1 || blklen_out !== 16'd40) begin
         n_err++;
         $display("FAIL frame_blklen_out: pulses %0d len %0d want 1/40", vbo_cnt, blklen_out);
      end
      n_cmp++;
      if (first_vb_cyc - vbo_cyc != 2) begin
         n_err++;
         $display("FAIL frame_latency: gap %0d want 2", first_vb_cyc - vbo_cyc);
      end
      n_cmp++;
      if (align_err != 0) begin
         n_err++;
         $display("FAIL valid_align: %0d misaligned cycles want 0", align_err);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL frame_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (cur_beat !== exp_q[exp_q.size() - 1]) begin
         n_err++;
         $display("FAIL frame_hold: got %h want %h", cur_beat, exp_q[exp_q.size() - 1]);
      end
   endtask

   task automatic test_saturation();
      bit ok;
      st_sys = '{32767, 32767, 32767, 32767};
      st_par = '{32767, 32767, 32767, 32767};
      st_apr = '{32767, 32767, 32767, 32767};
      clear_obs();
      model_frame(0);
      drive_frame(0, 0, -1);
      wait_idle(ok);
      n_cmp++;
      if (!ok || obs_q.size() != 4) begin
         n_err++;
         $display("FAIL sat_count: idle %0d beats %0d want 1/4", ok, obs_q.size());
      end
      if (obs_q.size() > 0) begin
         n_cmp++;
         if (obs_q[0][191:160] !== {16'h7fff, 16'h3fff}) begin
            n_err++;
            $display("FAIL sat_gamma: got %h want 7fff3fff", obs_q[0][191:160]);
         end
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL sat_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int blk;
      for (int f = 0; f < 4; f++) begin
         blk = int'($urandom_range(12, 0));
         gen_stim(blk + 4 + int'($urandom_range(3, 0)), (f == 3) ? 32767 : 8000);
         clear_obs();
         model_frame(blk);
         drive_frame(blk, 1, -1);
         wait_idle(ok);
         n_cmp++;
         if (!ok || obs_q.size() != blk + 4 || done_cnt != 1) begin
            n_err++;
            $display("FAIL b2b%0d_count: idle %0d beats %0d done %0d want 1/%0d/1",
                     f, ok, obs_q.size(), done_cnt, blk + 4);
         end
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL b2b%0d_beat%0d: got %h want %h", f, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      bit ok;
      logic [127:0] init_alpha;
      init_alpha = {16'(0), 16'(-128), 16'(-128), 16'(-128), 16'(-128),
                    16'(-128), 16'(-128), 16'(-128)};
      gen_stim(10, 2000);
      clear_obs();
      drive_frame(20, 0, -1);
      repeat (2) tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++;
         $display("FAIL abort_outputs: got %h want 0", all_out);
      end
      repeat (2) tick();
      rst = 1'b1;
      clear_obs();
      repeat (5) tick();
      n_cmp++;
      if (obs_q.size() != 0 || fsm_state !== 2'd0 || done_cnt != 0) begin
         n_err++;
         $display("FAIL abort_quiet: beats %0d state %0d done %0d want 0/0/0",
                  obs_q.size(), fsm_state, done_cnt);
      end
      gen_stim(6, 2000);
      clear_obs();
      model_frame(2);
      drive_frame(2, 1, -1);
      wait_idle(ok);
      n_cmp++;
      if (!ok || obs_q.size() != 6) begin
         n_err++;
         $display("FAIL abort_next_count: idle %0d beats %0d want 1/6", ok, obs_q.size());
      end
      if (obs_q.size() > 0) begin
         n_cmp++;
         if (obs_q[0][159:32] !== init_alpha) begin
            n_err++;
            $display("FAIL abort_init_alpha: got %h want %h", obs_q[0][159:32], init_alpha);
         end
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL abort_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_gamma_recursion();
      test_frame();
      test_saturation();
      test_back_to_back();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alpha_gamma_llr.md
ALPHA_GAMMA_LLR -- requirements
Module: alpha_gamma_llr

Interface
REQ-001 Parameter: blklen_w, 6144, maximum information block length accepted.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-low.
REQ-004 blklen / valid_blklen  input  16 / 1  frame length and its one-cycle qualifier.
REQ-005 sys, parity, apriori / valid_in  input  16 each / 1  signed channel LLRs and a-priori LLR for one trellis step.
REQ-006 init_branch1, init_branch2 / valid_branch  output  16 each / 1  signed branch metrics for the backward unit.
REQ-007 alpha_0 .. alpha_7 / valid_alpha  output  16 each / 1  signed forward state metrics, aligned with valid_branch.
REQ-008 sys_out / valid_sys, apriori_out / valid_apriori  output  16 / 1 each  delayed copies of sys and apriori, aligned with valid_branch.
REQ-009 blklen_out / valid_blklen_out  output  16 / 1  frame length forwarded to the backward unit.
REQ-010 done  output  1  one-cycle pulse after the final step of a frame.
REQ-011 fsm_state  output  2  current state encoding: IDLE=0, RUN=1, DRAIN=2.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DRAIN.
- IDLE->RUN on valid_blklen: latch blklen, load alpha to {0,-128 x7}, clear the step counter.
- RUN->DRAIN when the counter reaches L = blklen+4 accepted beats.
- DRAIN->IDLE after 2 cycles, pulsing done on the transition cycle.
REQ-013 valid_in SHALL be ignored outside RUN; valid_blklen SHALL be ignored outside IDLE.
REQ-014 valid_blklen_out SHALL be valid_blklen delayed 1 cycle (IDLE only), with blklen_out held from the latch.
- The first valid_branch therefore SHALL follow valid_blklen_out by at least 2 cycles.
REQ-015 Beats SHALL be accepted one per cycle with no backpressure; gaps in valid_in are allowed.
REQ-016 Latency SHALL be 2 cycles from an accepted valid_in to valid_branch; valid_alpha, valid_sys and valid_apriori SHALL equal valid_branch.
REQ-017 Branch metrics:
- s = sys + apriori (17-bit signed).
- g1 = (s + parity) >>> 1; g2 = (s - parity) >>> 1 (arithmetic shift, rounds toward -inf).
- Each result SHALL be saturated to [-32768, 32767].
REQ-018 Alpha registers a0..a7 SHALL be 19-bit signed; sign-extend the metrics before adding.
REQ-019 Per accepted beat, candidates:
- c0 = max(a0+g1, a1-g1); c1 = max(a3+g2, a2-g2)
- c2 = max(a4+g2, a5-g2); c3 = max(a7+g1, a6-g1)
- c4 = max(a1+g1, a0-g1); c5 = max(a2+g2, a3-g2)
- c6 = max(a5+g2, a4-g2); c7 = max(a6+g1, a7-g1)
REQ-020 Normalisation: new a_t = c_t - c0, so a0 = 0 after every step.
REQ-021 The outputs for step k SHALL be alpha_k (the value before g_k is consumed), paired with g1_k and g2_k.
- alpha_x SHALL be the 19-bit value saturated to 16 bits.
REQ-022 Exactly L beats of valid_branch SHALL be emitted per frame; beats beyond L SHALL be ignored.
REQ-023 Outputs SHALL hold their last value while the matching valid is low.

Reset
REQ-024 While rst is low, all outputs, counters and valids SHALL be 0 and state SHALL be IDLE.
REQ-025 Reset mid-frame SHALL abort the frame; no valid pulses follow, and the next frame restarts from the initial alphas.

Verification
REQ-026 Reset: rst=0 -> all outputs 0, fsm_state=0; rst=1 with no stimulus -> outputs stay 0.
REQ-027 Gamma: sys=10, apriori=4, parity=6 -> init_branch1=10, init_branch2=4; sys=-3, apriori=0, parity=0 -> both -2.
REQ-028 Recursion, with g1=10 and g2=4 on the first beat:
- Beat 0 -> alpha = 0, -128 x7.
- Beat 1 -> alpha = 0, -134, -134, -128, -20, -134, -134, -128.
REQ-029 Frame: blklen=40 with 50 valid_in beats -> exactly 44 valid_branch pulses, then done pulses once and fsm_state returns to 0.
REQ-030 Saturation: sys=apriori=parity=32767 -> init_branch1=32767, init_branch2=16383.
REQ-031 Abort: rst low after 10 steps -> outputs 0 at once; the next frame's first alpha = 0, -128 x7.
